dzmcu_dma: RTL
==============

Name: dzmcu_dma

Overview:
- Memory-control stage directly downstream of the CPU core's MCU bus (address, read data, write data, write enable).
- Owns the external memory bus and an internal HRAM.
- Implements the GB OAM DMA engine: a CPU write to FF46 copies 160 bytes from {src,8'h00} into OAM at FE00–FE9F.
- During a DMA the CPU keeps running from HRAM only.

Parameters:
- DMA_LEN, 160, number of bytes per OAM DMA transfer
- OAM_BASE, 16'hFE00, destination base address
- DMA_REG, 16'hFF46, DMA trigger/source register address
- HRAM_LO, 16'hFF80, first HRAM address (HRAM spans HRAM_LO..16'hFFFE, 127 bytes)

Ports:
- iClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iCpuAddr  in  16  CPU bus address
- iCpuData  in  8  CPU write data
- iCpuWe  in  1  CPU write strobe, one byte per cycle while high
- oCpuData  out  8  CPU read data, combinational from iCpuAddr
- oMemAddr  out  16  external memory address
- oMemData  out  8  external memory write data
- iMemData  in  8  external memory read data; asynchronous read, valid in the same cycle
- oMemWe  out  1  external memory write strobe; memory writes on posedge
- oDmaBusy  out  1  high while a DMA owns the external bus

Behaviour:
- Reset, synchronous on iReset:
  - state IDLE, byte counter 0, FF46 register 0, data latch 0.
  - oDmaBusy=0, oMemWe=0.
  - HRAM contents are not reset.
- FSM states: IDLE, START, RD, WR.
  - IDLE -> START on a CPU write to DMA_REG.
  - START -> RD after 1 cycle (setup delay).
  - RD -> WR after 1 cycle.
  - WR -> RD if counter < DMA_LEN-1; else -> IDLE.
  - Counter increments on WR exit.
- RD cycle:
  - oMemAddr = {src,counter}.
  - Latch iMemData into the data register at the clock edge.
  - oMemWe=0.
- WR cycle:
  - oMemAddr = OAM_BASE + counter, oMemData = latched byte, oMemWe=1.
- Total DMA length: 1 + 2*DMA_LEN = 321 cycles.
  - oDmaBusy is high in START, RD and WR.
  - oDmaBusy is low the cycle after the last WR.
- Source mapping:
  - Register value 8'hE0–8'hFF: bit 5 is cleared to form src (echo -> C0–DF).
  - Readback of FF46 returns the value as written.
- IDLE, CPU path:
  - Non-HRAM addresses other than DMA_REG: oMemAddr=iCpuAddr, oMemData=iCpuData, oMemWe=iCpuWe, oCpuData=iMemData.
  - HRAM and DMA_REG are serviced internally. oMemWe=0 for those addresses.
- Busy, CPU path:
  - HRAM reads and writes and DMA_REG accesses work normally.
  - Any other CPU read returns 8'hFF.
  - Any other CPU write is dropped.
- Address FFFF (IE) is not HRAM and is always forwarded to external memory when idle.
- Restart: a CPU write to DMA_REG while busy, including on the final WR cycle:
  - Loads the new source.
  - Clears the counter.
  - Goes to START; the in-flight WR still completes that cycle.
- Reset mid-DMA: returns to IDLE next edge; the partial OAM copy is left as-is.
- Widths:
  - Counter is 8 bits.
  - OAM address = OAM_BASE + {8'h00,counter}; no wrap occurs for DMA_LEN ≤ 256.

Decomposition:
- Shared package/defines (alongside the existing aDefinitions):
  - state encodings DMA_IDLE/START/RD/WR
  - DMA_REG, OAM_BASE, HRAM_LO constants
  - address-decode helper macros (is_hram, is_dma_reg)
- One natural sub-module: dzmcu_hram.
  - 127x8 RAM, asynchronous read, synchronous write.
  - Ports: clock, we, 7-bit addr, wdata, rdata.
- The FSM and bus muxing stay in dzmcu_dma.

Test Plan:
- Idle passthrough: CPU writes 8'h5A to C123, then reads C123 -> oMemWe=1 with oMemAddr=C123/oMemData=5A on the write cycle; read returns the memory model's 5A; oDmaBusy=0.
- Full DMA: preload C000–C09F with index^8'h3C, CPU writes 8'hC0 to FF46 -> oDmaBusy rises the next cycle; exactly 160 oMemWe pulses at FE00..FE9F with the matching data; busy drops after 321 cycles; FF46 reads C0.
- CPU during DMA: read C000 -> 8'hFF; write D000 -> no oMemWe outside WR cycles; HRAM write FF90=8'h77 then read -> 8'h77.
- Echo source: write 8'hE1 to FF46 -> RD addresses are C100..C19F.
- Restart: at byte 50, write 8'hD0 to FF46 -> the next RD after START is D000; 160 further writes follow, starting at FE00.
- Reset mid-DMA at byte 80 -> next cycle oDmaBusy=0 and oMemWe=0; FF46 reads 00; a subsequent idle passthrough works.

Source files
------------

// File: rtl/dzmcu_dma_pkg.sv
// dzmcu_dma_pkg: shared OAM DMA constants, FSM state encoding and address-decode helpers
// No ports; imported by dzmcu_dma and dzmcu_hram.
package dzmcu_dma_pkg;
    localparam int          DMA_LEN  = 160;
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [15:0] DMA_REG  = 16'hFF46;
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [7:0]  DMA_LAST = 8'(DMA_LEN - 1);
    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_RD, DMA_WR} dma_state_t;
    // FFFF (IE) sits above HRAM but belongs to external memory
    function automatic logic is_hram(input logic [15:0] a);
        return a >= HRAM_LO && a != 16'hFFFF;
    endfunction
    function automatic logic is_dma_reg(input logic [15:0] a);
        return a == DMA_REG;
    endfunction
endpackage

// File: rtl/dzmcu_hram.sv
// dzmcu_hram: 127x8 high RAM, asynchronous read, synchronous write
// Ports: iClock clock; iWe write strobe; iAddr 7-bit byte address;
//        iData write data; oData read data (combinational from iAddr).
import dzmcu_dma_pkg::*;
module dzmcu_hram (
    input  logic       iClock,
    input  logic       iWe,
    input  logic [6:0] iAddr,
    input  logic [7:0] iData,
    output logic [7:0] oData
);
    logic [7:0] r_mem [0:126];
    always_ff @(posedge iClock)
        if (iWe) r_mem[iAddr] <= iData;
    assign oData = r_mem[iAddr];
endmodule

// File: rtl/dzmcu_dma.sv
// dzmcu_dma: memory-control stage owning the external bus, HRAM and the OAM DMA engine
// Ports: iClock/iReset clock and synchronous active-high reset;
//        iCpuAddr/iCpuData/iCpuWe CPU bus in, oCpuData CPU read data (combinational);
//        oMemAddr/oMemData/oMemWe/iMemData external memory bus (async read, posedge write);
//        oDmaBusy high while a DMA owns the external bus.
import dzmcu_dma_pkg::*;
module dzmcu_dma (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    input  logic [7:0]  iMemData,
    output logic        oMemWe,
    output logic        oDmaBusy
);
    dma_state_t r_state, w_next;
    logic [7:0] r_cnt, r_dma, r_data, w_src, w_hram_rd;
    logic       w_hram, w_dreg, w_trig, w_busy;
    assign w_hram = is_hram(iCpuAddr);
    assign w_dreg = is_dma_reg(iCpuAddr);
    assign w_trig = iCpuWe && w_dreg;
    assign w_busy = r_state != DMA_IDLE;
    // echo RAM sources E0-FF fold onto C0-DF
    assign w_src  = (r_dma[7:5] == 3'b111) ? {r_dma[7:6], 1'b0, r_dma[4:0]} : r_dma;
    dzmcu_hram u_hram (
        .iClock (iClock),
        .iWe    (iCpuWe && w_hram),
        .iAddr  (iCpuAddr[6:0]),
        .iData  (iCpuData),
        .oData  (w_hram_rd)
    );
    always_ff @(posedge iClock)
        r_state <= iReset ? DMA_IDLE : w_next;
    // a write to the DMA register restarts from any state, even the final WR
    always_comb
        w_next = w_trig                                ? DMA_START :
                 r_state == DMA_START                  ? DMA_RD    :
                 r_state == DMA_RD                     ? DMA_WR    :
                 r_state == DMA_WR && r_cnt < DMA_LAST ? DMA_RD    : DMA_IDLE;
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_cnt  <= '0;
            r_dma  <= '0;
            r_data <= '0;
        end else begin
            if (w_trig) r_dma <= iCpuData;
            if (w_trig) r_cnt <= '0;
            else if (r_state == DMA_WR) r_cnt <= r_cnt + 8'd1;
            if (r_state == DMA_RD) r_data <= iMemData;
        end
    end
    always_comb begin
        oMemAddr = iCpuAddr;
        oMemData = iCpuData;
        oMemWe   = 1'b0;
        case (r_state)
            DMA_START, DMA_RD: oMemAddr = {w_src, r_cnt};
            DMA_WR: begin
                oMemAddr = OAM_BASE + {8'h00, r_cnt};
                oMemData = r_data;
                oMemWe   = 1'b1;
            end
            default: oMemWe = iCpuWe && !w_hram && !w_dreg;
        endcase
        // while busy the external bus is unavailable to the CPU
        oCpuData = w_hram ? w_hram_rd : w_dreg ? r_dma : w_busy ? 8'hFF : iMemData;
        oDmaBusy = w_busy;
    end
endmodule
